mult_op_sequencer: RTL and testbench

- Clocked front/back-end stage wrapped around the 4x4 combinational array multiplier.
- Accepts operand pairs over a valid/ready handshake and drives them onto the multiplier's m/q inputs.
- Holds the operands stable for a programmable settle time, then captures the 8-bit product and presents it downstream over a valid/ready handshake.
- Optionally accumulates products into a wrap-around accumulator with a sticky overflow flag.

---
 rtl/mult_op_sequencer.sv | 100 ++++++++++
 tb/tb_mult_op_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_op_sequencer.sv
// Clocked sequencer around an external 4x4 combinational multiplier: it accepts operands,
// holds them for a settle time, captures the product and optionally accumulates it.
module mult_op_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned ACC_W         = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_a,
   input  logic [3:0]       in_b,
   input  logic             in_acc,
   input  logic             acc_clr,
   output logic [3:0]       mult_m,
   output logic [3:0]       mult_q,
   input  logic [7:0]       mult_p,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_prod,
   output logic [ACC_W-1:0] out_acc,
   output logic             acc_ovf,
   output logic             busy
);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 7) begin : g_bad_settle
      $error("SETTLE_CYCLES must be in 1..7");
   end
   if (ACC_W < 8) begin : g_bad_acc_w
      $error("ACC_W must be at least 8");
   end

   typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

   state_e           state;
   logic [2:0]       cnt;
   logic             acc_flag;
   logic [ACC_W-1:0] acc_base;
   logic [ACC_W:0]   acc_sum;

   // Clear takes effect before the add when both land on the same edge.
   always_comb begin
      acc_base = acc_clr ? '0 : out_acc;
      acc_sum  = {1'b0, acc_base} + {{(ACC_W - 7){1'b0}}, mult_p};
   end

   assign in_ready = (state == StIdle);
   assign busy     = ~in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= StIdle;
         cnt       <= '0;
         acc_flag  <= 1'b0;
         mult_m    <= '0;
         mult_q    <= '0;
         out_prod  <= '0;
         out_acc   <= '0;
         acc_ovf   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (acc_clr) begin
            out_acc <= '0;
            acc_ovf <= 1'b0;
         end
         case (state)
            StIdle: begin
               if (in_valid) begin
                  mult_m   <= in_a;
                  mult_q   <= in_b;
                  acc_flag <= in_acc;
                  cnt      <= 3'(SETTLE_CYCLES - 1);
                  state    <= StSettle;
               end
            end
            StSettle: begin
               if (cnt != 3'd0) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  out_prod  <= mult_p;
                  out_valid <= 1'b1;
                  state     <= StDone;
                  if (acc_flag) begin
                     out_acc <= acc_sum[ACC_W-1:0];
                     acc_ovf <= (acc_ovf & ~acc_clr) | acc_sum[ACC_W];
                  end
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_op_sequencer.sv
// Scoreboard bench for two sequencer instances (settle 1 and settle 3) against an arithmetic model.
module tb_mult_op_sequencer;

   localparam int unsigned AccW = 12;
   localparam int AccMod = 1 << AccW;

   logic            clk;
   logic            rst_n     [2];
   logic            in_valid  [2];
   logic            in_ready  [2];
   logic [3:0]      in_a      [2];
   logic [3:0]      in_b      [2];
   logic            in_acc    [2];
   logic            acc_clr   [2];
   logic [3:0]      mult_m    [2];
   logic [3:0]      mult_q    [2];
   logic [7:0]      mult_p    [2];
   logic            out_valid [2];
   logic            out_ready [2];
   logic [7:0]      out_prod  [2];
   logic [AccW-1:0] out_acc   [2];
   logic            acc_ovf   [2];
   logic            busy      [2];

   // Behavioural stand-in for the combinational array multiplier.
   assign mult_p[0] = 8'(mult_m[0]) * 8'(mult_q[0]);
   assign mult_p[1] = 8'(mult_m[1]) * 8'(mult_q[1]);

   mult_op_sequencer #(.SETTLE_CYCLES(1), .ACC_W(AccW)) u_dut0 (
      .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_a(in_a[0]), .in_b(in_b[0]), .in_acc(in_acc[0]), .acc_clr(acc_clr[0]),
      .mult_m(mult_m[0]), .mult_q(mult_q[0]), .mult_p(mult_p[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_prod(out_prod[0]),
      .out_acc(out_acc[0]), .acc_ovf(acc_ovf[0]), .busy(busy[0])
   );

   mult_op_sequencer #(.SETTLE_CYCLES(3), .ACC_W(AccW)) u_dut1 (
      .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_a(in_a[1]), .in_b(in_b[1]), .in_acc(in_acc[1]), .acc_clr(acc_clr[1]),
      .mult_m(mult_m[1]), .mult_q(mult_q[1]), .mult_p(mult_p[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_prod(out_prod[1]),
      .out_acc(out_acc[1]), .acc_ovf(acc_ovf[1]), .busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int   d;
      int   prod;
      int   acc;
      int   ovf;
      int   acc_cyc;
   } exp_t;

   exp_t sb[$];
   bit   lat_done = 1'b0;
   int   checks   = 0;
   int   errors   = 0;
   int   m_acc [2];
   int   m_ovf [2];
   bit   rnd_ready = 1'b0;

   function automatic int settle(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: latency on first sight of out_valid, payload on each completed handshake.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (out_valid[d]) begin
            if (sb.size() == 0 || sb[0].d != d) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out dut%0d: got prod %0d expected no result",
                        d, out_prod[d]);
            end else begin
               if (!lat_done) begin
                  lat_done = 1'b1;
                  chk($sformatf("latency_dut%0d", d), cyc - sb[0].acc_cyc, settle(d));
               end
               if (out_ready[d]) begin
                  chk($sformatf("prod_dut%0d", d), int'(out_prod[d]), sb[0].prod);
                  chk($sformatf("acc_dut%0d", d), int'(out_acc[d]), sb[0].acc);
                  chk($sformatf("ovf_dut%0d", d), int'(acc_ovf[d]), sb[0].ovf);
                  void'(sb.pop_front());
                  lat_done = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready) out_ready[0] = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation; returns 1 ns after the accepting edge.
   task automatic issue(input int d, input int a, input int b, input bit acc,
                        input bit clr, input bit expect_out);
      int   n = 0;
      exp_t e;
      while (!in_ready[d] && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) begin
         chk($sformatf("in_ready_timeout_dut%0d", d), 0, 1);
         return;
      end
      in_valid[d] = 1'b1;
      in_a[d]     = 4'(a);
      in_b[d]     = 4'(b);
      in_acc[d]   = acc;
      step();
      in_valid[d] = 1'b0;
      in_a[d]     = 4'($urandom);
      in_b[d]     = 4'($urandom);
      in_acc[d]   = 1'($urandom);
      if (expect_out) begin
         if (clr) begin
            m_acc[d] = 0;
            m_ovf[d] = 0;
         end
         if (acc) begin
            m_acc[d] = m_acc[d] + a * b;
            if (m_acc[d] >= AccMod) begin
               m_acc[d] = m_acc[d] - AccMod;
               m_ovf[d] = 1;
            end
         end
         e.d       = d;
         e.prod    = a * b;
         e.acc     = m_acc[d];
         e.ovf     = m_ovf[d];
         e.acc_cyc = cyc;
         sb.push_back(e);
      end
      if (clr) begin
         repeat (settle(d) - 1) step();
         acc_clr[d] = 1'b1;
         step();
         acc_clr[d] = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         step();
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
         lat_done = 1'b0;
      end
   endtask

   task automatic chk_reset_state(input int d);
      chk($sformatf("rst_in_ready_dut%0d", d), int'(in_ready[d]), 1);
      chk($sformatf("rst_busy_dut%0d", d), int'(busy[d]), 0);
      chk($sformatf("rst_out_valid_dut%0d", d), int'(out_valid[d]), 0);
      chk($sformatf("rst_out_prod_dut%0d", d), int'(out_prod[d]), 0);
      chk($sformatf("rst_out_acc_dut%0d", d), int'(out_acc[d]), 0);
      chk($sformatf("rst_acc_ovf_dut%0d", d), int'(acc_ovf[d]), 0);
      chk($sformatf("rst_mult_m_dut%0d", d), int'(mult_m[d]), 0);
      chk($sformatf("rst_mult_q_dut%0d", d), int'(mult_q[d]), 0);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; in_valid[d] = 1'b0; in_a[d] = '0; in_b[d] = '0;
         in_acc[d] = 1'b0; acc_clr[d] = 1'b0; out_ready[d] = 1'b1;
         m_acc[d] = 0; m_ovf[d] = 0;
      end
      repeat (2) step();
      chk_reset_state(0);
      chk_reset_state(1);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      step();

      // 15x15 without accumulate; in_ready returns one edge after capture.
      issue(0, 15, 15, 1'b0, 1'b0, 1'b1);
      step();
      chk("busy_at_capture", int'(in_ready[0]), 0);
      step();
      chk("ready_after_handshake", int'(in_ready[0]), 1);
      drain();

      for (int i = 0; i < 3; i++) issue(0, 9, 6, 1'b1, 1'b0, 1'b1);
      drain();

      // Clear, then 19 accumulations of 225 wrap past 4095, then 2x3 keeps the sticky flag.
      acc_clr[0] = 1'b1;
      step();
      acc_clr[0] = 1'b0;
      m_acc[0] = 0;
      m_ovf[0] = 0;
      chk("idle_clr_acc", int'(out_acc[0]), 0);
      for (int i = 0; i < 19; i++) issue(0, 15, 15, 1'b1, 1'b0, 1'b1);
      issue(0, 2, 3, 1'b1, 1'b0, 1'b1);
      drain();

      // Backpressure with an ignored in_valid while DONE.
      out_ready[0] = 1'b0;
      issue(0, 7, 3, 1'b0, 1'b0, 1'b1);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", int'(out_valid[0]), 1);
         chk("bp_out_prod", int'(out_prod[0]), 21);
         chk("bp_in_ready", int'(in_ready[0]), 0);
         in_valid[0] = (i == 2);
         in_a[0] = 4'd1;
         in_b[0] = 4'd1;
         step();
      end
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      step();
      chk("bp_released_valid", int'(out_valid[0]), 0);
      chk("bp_prod_holds", int'(out_prod[0]), 21);
      repeat (3) step();

      // Clear coincident with an accumulate capture.
      issue(0, 4, 5, 1'b1, 1'b1, 1'b1);
      drain();

      // Randomised traffic with random backpressure and occasional clear-at-capture.
      rnd_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         issue(0, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom),
               ($urandom_range(0, 7) == 0), 1'b1);
      end
      drain();
      rnd_ready = 1'b0;
      out_ready[0] = 1'b1;

      // Settle-3 instance: accumulate, then abort with reset on the 2nd settle edge.
      for (int i = 0; i < 4; i++) begin
         issue(1, $urandom_range(0, 15), $urandom_range(0, 15), 1'b1, 1'b0, 1'b1);
      end
      drain();
      issue(1, 12, 10, 1'b1, 1'b0, 1'b0);
      in_a[1] = 4'd3;
      step();
      rst_n[1] = 1'b0;
      step();
      chk_reset_state(1);
      rst_n[1] = 1'b1;
      m_acc[1] = 0;
      m_ovf[1] = 0;
      repeat (6) step();
      issue(1, 12, 10, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         issue(1, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom),
               ($urandom_range(0, 3) == 0), 1'b1);
      end
      drain();
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
